// File: rtl/jt12_lfo_gen.sv
// rtl/jt12_lfo_gen.sv - LFO phase generator for the FM operator pipeline
//
// Purpose: counts qualified sample ticks and advances a 7-bit LFO phase
// once every P ticks. P is selected by lfo_freq from the table
// 108, 77, 71, 67, 62, 44, 8, 5.
//
// Optional feature macro: JT12_LFO_AM_EN adds the registered am_mod
// triangle output. Without it the port and its register are absent.
//
// Ports:
//   rst       in   1  synchronous reset, active high
//   clk       in   1  system clock
//   clk_en    in   1  global clock enable
//   zero      in   1  sample tick, counted only when clk_en is high
//   lfo_en    in   1  LFO enable
//   lfo_freq  in   3  LFO rate select
//   lfo_mod   out  7  LFO phase, wraps 127 -> 0
//   pm_mod    out  5  lfo_mod[6:2]
//   lfo_step  out  1  one-clk pulse in the cycle after lfo_mod advanced
//   am_mod    out  6  AM triangle level (JT12_LFO_AM_EN only)
module jt12_lfo_gen #(
  parameter int CNTW = 7
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       clk_en,
  input  logic       zero,
  input  logic       lfo_en,
  input  logic [2:0] lfo_freq,
  output logic [6:0] lfo_mod,
  output logic [4:0] pm_mod,
  output logic       lfo_step
`ifdef JT12_LFO_AM_EN
  ,
  output logic [5:0] am_mod
`endif
);

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] limit;
  logic [6:0]      mod_nxt;
  logic            tick;

  // The limit is period-1 and is decoded from the live register value.
  // A rate change therefore takes effect on the very next tick.
  always_comb begin
    limit = CNTW'(107);
    case (lfo_freq)
      3'd0: limit = CNTW'(107);
      3'd1: limit = CNTW'(76);
      3'd2: limit = CNTW'(70);
      3'd3: limit = CNTW'(66);
      3'd4: limit = CNTW'(61);
      3'd5: limit = CNTW'(43);
      3'd6: limit = CNTW'(7);
      3'd7: limit = CNTW'(4);
      default: limit = CNTW'(107);
    endcase
  end

  assign tick    = clk_en & zero;
  assign mod_nxt = lfo_mod + 7'd1;
  assign pm_mod  = lfo_mod[6:2];

`ifdef JT12_LFO_AM_EN
  logic [5:0] am_nxt;
  // The triangle level is taken from the phase value being loaded.
  // This keeps am_mod aligned with lfo_mod in the same cycle.
  assign am_nxt = mod_nxt[6] ? ~mod_nxt[5:0] : mod_nxt[5:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      lfo_mod  <= '0;
      lfo_step <= 1'b0;
`ifdef JT12_LFO_AM_EN
      am_mod   <= '0;
`endif
    end else begin
      // The step pulse clears every clk, not only on clk_en cycles.
      // This keeps the pulse one clk wide.
      lfo_step <= 1'b0;
      if (tick) begin
        if (lfo_en) begin
          // The >= compare, rather than ==, makes a count already past
          // a newly lowered limit step at once instead of wrapping.
          if (cnt >= limit) begin
            cnt      <= '0;
            lfo_mod  <= mod_nxt;
            lfo_step <= 1'b1;
`ifdef JT12_LFO_AM_EN
            am_mod   <= am_nxt;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          // The LFO is held cleared while disabled.
          // Clearing happens only on a tick, so lfo_mod lingers until then.
          cnt     <= '0;
          lfo_mod <= '0;
`ifdef JT12_LFO_AM_EN
          am_mod  <= '0;
`endif
        end
      end
    end
  end

endmodule
